// File: rtl/id_ex_if.sv
// Bundle between decode, the forwarding sources, the ALU and EX/MEM for the ID/EX stage.
// The master side drives decode/forwarding inputs; the slave side is the ID/EX stage itself.
interface id_ex_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [3:0]      id_alu_ctrl;
    logic            id_alu_src_a;
    logic            id_alu_src_b;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;
    logic [XLEN-1:0] alu_d0;
    logic [XLEN-1:0] alu_d1;
    logic [3:0]      alu_s;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [XLEN-1:0] ex_store_data;
    logic            load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_alu_src_a, id_alu_src_b,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        input  alu_d0, alu_d1, alu_s, ex_valid, ex_pc, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_ctrl, id_alu_src_a, id_alu_src_b,
               id_reg_write, id_mem_read, id_mem_write,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        output alu_d0, alu_d1, alu_s, ex_valid, ex_pc, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_store_data, load_use_hazard
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, ALU operand muxing and
// load-use hazard detection for the RV32I pipeline.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    id_ex_if.slave  bus
);

    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_fields_t;

    ex_fields_t      ex_p1;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // MEM result beats WB result; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd_pick(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] latched,
        input logic [4:0]      m_rd,
        input logic            m_we,
        input logic [XLEN-1:0] m_val,
        input logic [4:0]      w_rd,
        input logic            w_we,
        input logic [XLEN-1:0] w_val
    );
        logic [XLEN-1:0] res;
        res = latched;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            res = m_val;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            res = w_val;
        end
        return res;
    endfunction

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_p1 <= '0;
        end else if (bus.flush) begin
            ex_p1 <= '0;
        end else if (bus.stall) begin
            // Refresh operands so a forwarding source retiring mid-stall is not lost.
            ex_p1.rs1_data <= fwd_rs1;
            ex_p1.rs2_data <= fwd_rs2;
        end else begin
            ex_p1.vld       <= bus.id_valid;
            ex_p1.pc        <= bus.id_pc;
            ex_p1.rs1_data  <= bus.id_rs1_data;
            ex_p1.rs2_data  <= bus.id_rs2_data;
            ex_p1.imm       <= bus.id_imm;
            ex_p1.rs1       <= bus.id_rs1;
            ex_p1.rs2       <= bus.id_rs2;
            ex_p1.rd        <= bus.id_rd;
            ex_p1.alu_ctrl  <= bus.id_alu_ctrl;
            ex_p1.alu_src_a <= bus.id_alu_src_a;
            ex_p1.alu_src_b <= bus.id_alu_src_b;
            ex_p1.reg_write <= bus.id_reg_write & bus.id_valid;
            ex_p1.mem_read  <= bus.id_mem_read  & bus.id_valid;
            ex_p1.mem_write <= bus.id_mem_write & bus.id_valid;
        end
    end

    // ---- EX operand front end (combinational) ----
    always_comb begin
        fwd_rs1 = fwd_pick(ex_p1.rs1, ex_p1.rs1_data,
                           bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                           bus.wb_rd, bus.wb_reg_write, bus.wb_result);
        fwd_rs2 = fwd_pick(ex_p1.rs2, ex_p1.rs2_data,
                           bus.mem_rd, bus.mem_reg_write, bus.mem_result,
                           bus.wb_rd, bus.wb_reg_write, bus.wb_result);
    end

    assign bus.alu_d0        = ex_p1.alu_src_a ? ex_p1.pc  : fwd_rs1;
    assign bus.alu_d1        = ex_p1.alu_src_b ? ex_p1.imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.alu_s         = ex_p1.vld ? ex_p1.alu_ctrl : 4'b0000;

    assign bus.ex_valid      = ex_p1.vld;
    assign bus.ex_pc         = ex_p1.pc;
    assign bus.ex_rd         = ex_p1.rd;
    assign bus.ex_reg_write  = ex_p1.reg_write;
    assign bus.ex_mem_read   = ex_p1.mem_read;
    assign bus.ex_mem_write  = ex_p1.mem_write;

    // Conservative: compares both source indices even if the ID instruction ignores one.
    assign bus.load_use_hazard = ex_p1.vld && ex_p1.mem_read && (ex_p1.rd != 5'd0) &&
                                 bus.id_valid &&
                                 ((bus.id_rs1 == ex_p1.rd) || (bus.id_rs2 == ex_p1.rd));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_if #(.XLEN(32)) b ();

    id_ex_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of what the EX slot currently holds.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu_ctrl;
        logic        src_a;
        logic        src_b;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } slot_t;

    slot_t m;

    function automatic logic [31:0] model_operand(input logic [4:0] r, input logic [31:0] lat);
        if (b.mem_reg_write && r != 0 && b.mem_rd == r) return b.mem_result;
        if (b.wb_reg_write && r != 0 && b.wb_rd == r) return b.wb_result;
        return lat;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] op1, op2;
        logic        hz;
        op1 = model_operand(m.rs1, m.rs1_data);
        op2 = model_operand(m.rs2, m.rs2_data);
        hz  = m.valid && m.mem_read && m.rd != 0 && b.id_valid &&
              (b.id_rs1 == m.rd || b.id_rs2 == m.rd);
        chk({tag, ".alu_d0"},   b.alu_d0,          m.src_a ? m.pc : op1);
        chk({tag, ".alu_d1"},   b.alu_d1,          m.src_b ? m.imm : op2);
        chk({tag, ".alu_s"},    {28'd0, b.alu_s},  m.valid ? {28'd0, m.alu_ctrl} : 32'd0);
        chk({tag, ".valid"},    {31'd0, b.ex_valid},     {31'd0, m.valid});
        chk({tag, ".pc"},       b.ex_pc,                 m.pc);
        chk({tag, ".rd"},       {27'd0, b.ex_rd},        {27'd0, m.rd});
        chk({tag, ".rw"},       {31'd0, b.ex_reg_write}, {31'd0, m.reg_write});
        chk({tag, ".mr"},       {31'd0, b.ex_mem_read},  {31'd0, m.mem_read});
        chk({tag, ".mw"},       {31'd0, b.ex_mem_write}, {31'd0, m.mem_write});
        chk({tag, ".store"},    b.ex_store_data,         op2);
        chk({tag, ".hazard"},   {31'd0, b.load_use_hazard}, {31'd0, hz});
    endtask

    // One rising edge: model and DUT both see the same settled inputs.
    task automatic clk_edge();
        logic [31:0] n1, n2;
        @(posedge clk);
        if (rst_n) begin
            if (b.flush) begin
                m = '0;
            end else if (b.stall) begin
                n1 = model_operand(m.rs1, m.rs1_data);
                n2 = model_operand(m.rs2, m.rs2_data);
                m.rs1_data = n1;
                m.rs2_data = n2;
            end else begin
                m.valid     = b.id_valid;
                m.pc        = b.id_pc;
                m.rs1_data  = b.id_rs1_data;
                m.rs2_data  = b.id_rs2_data;
                m.imm       = b.id_imm;
                m.rs1       = b.id_rs1;
                m.rs2       = b.id_rs2;
                m.rd        = b.id_rd;
                m.alu_ctrl  = b.id_alu_ctrl;
                m.src_a     = b.id_alu_src_a;
                m.src_b     = b.id_alu_src_b;
                m.reg_write = b.id_valid ? b.id_reg_write : 1'b0;
                m.mem_read  = b.id_valid ? b.id_mem_read  : 1'b0;
                m.mem_write = b.id_valid ? b.id_mem_write : 1'b0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        b.stall = 0; b.flush = 0; b.id_valid = 0;
        b.id_pc = 0; b.id_rs1_data = 0; b.id_rs2_data = 0; b.id_imm = 0;
        b.id_rs1 = 0; b.id_rs2 = 0; b.id_rd = 0; b.id_alu_ctrl = 0;
        b.id_alu_src_a = 0; b.id_alu_src_b = 0;
        b.id_reg_write = 0; b.id_mem_read = 0; b.id_mem_write = 0;
        b.mem_rd = 0; b.mem_reg_write = 0; b.mem_result = 0;
        b.wb_rd = 0; b.wb_reg_write = 0; b.wb_result = 0;
    endtask

    task automatic randomize_inputs();
        b.stall         = ($urandom_range(0, 4) == 0);
        b.flush         = ($urandom_range(0, 9) == 0);
        b.id_valid      = ($urandom_range(0, 5) != 0);
        b.id_pc         = $urandom;
        b.id_rs1_data   = $urandom;
        b.id_rs2_data   = $urandom;
        b.id_imm        = $urandom;
        b.id_rs1        = 5'($urandom_range(0, 7));
        b.id_rs2        = 5'($urandom_range(0, 7));
        b.id_rd         = 5'($urandom_range(0, 7));
        b.id_alu_ctrl   = 4'($urandom_range(0, 9));
        b.id_alu_src_a  = 1'($urandom_range(0, 1));
        b.id_alu_src_b  = 1'($urandom_range(0, 1));
        b.id_reg_write  = 1'($urandom_range(0, 1));
        b.id_mem_read   = 1'($urandom_range(0, 1));
        b.id_mem_write  = 1'($urandom_range(0, 1));
        b.mem_rd        = 5'($urandom_range(0, 7));
        b.mem_reg_write = 1'($urandom_range(0, 1));
        b.mem_result    = $urandom;
        b.wb_rd         = 5'($urandom_range(0, 7));
        b.wb_reg_write  = 1'($urandom_range(0, 1));
        b.wb_result     = $urandom;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m      = '0;
        rst_n  = 1'b0;
        clear_inputs();

        // Reset state
        #2;
        chk("rst.valid",  {31'd0, b.ex_valid}, 32'd0);
        chk("rst.alu_s",  {28'd0, b.alu_s},    32'd0);
        chk("rst.alu_d0", b.alu_d0,            32'd0);
        chk("rst.alu_d1", b.alu_d1,            32'd0);
        check_all("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Forwarding priority: MEM over WB, then WB alone
        b.id_valid = 1; b.id_rs1 = 5; b.id_rs1_data = 32'h55; b.id_alu_ctrl = 4'd0;
        b.id_reg_write = 1; b.id_rd = 9;
        clk_edge();
        clear_inputs();
        b.mem_rd = 5; b.mem_reg_write = 1; b.mem_result = 32'h11111111;
        b.wb_rd  = 5; b.wb_reg_write  = 1; b.wb_result  = 32'h22222222;
        #1;
        chk("fwd_mem_wins", b.alu_d0, 32'h11111111);
        check_all("fwd_mem");
        b.mem_reg_write = 0;
        #1;
        chk("fwd_wb", b.alu_d0, 32'h22222222);
        check_all("fwd_wb");

        // x0 guard
        clear_inputs();
        b.id_valid = 1; b.id_rs2 = 0; b.id_rs2_data = 0; b.id_alu_src_b = 0; b.id_mem_write = 1;
        clk_edge();
        clear_inputs();
        b.mem_rd = 0; b.mem_reg_write = 1; b.mem_result = 32'hDEADBEEF;
        #1;
        chk("x0.alu_d1", b.alu_d1, 32'd0);
        chk("x0.store",  b.ex_store_data, 32'd0);
        check_all("x0");

        // Flush beats stall
        clear_inputs();
        b.id_valid = 1; b.id_alu_ctrl = 4'd0; b.id_reg_write = 1; b.id_rd = 4; b.id_pc = 32'h100;
        clk_edge();
        clear_inputs();
        b.stall = 1; b.flush = 1;
        clk_edge();
        clear_inputs();
        #1;
        chk("flush.valid", {31'd0, b.ex_valid},     32'd0);
        chk("flush.rw",    {31'd0, b.ex_reg_write}, 32'd0);
        chk("flush.alu_s", {28'd0, b.alu_s},        32'd0);
        check_all("flush");

        // Load-use hazard, then rd=x0 never hazards
        b.id_valid = 1; b.id_rd = 7; b.id_mem_read = 1; b.id_reg_write = 1; b.id_alu_src_b = 1;
        clk_edge();
        clear_inputs();
        b.id_valid = 1; b.id_rs1 = 1; b.id_rs2 = 7; b.id_rd = 2;
        #1;
        chk("lu.hit", {31'd0, b.load_use_hazard}, 32'd1);
        check_all("lu_hit");
        clear_inputs();
        b.id_valid = 1; b.id_rd = 0; b.id_mem_read = 1; b.id_reg_write = 1;
        clk_edge();
        clear_inputs();
        b.id_valid = 1; b.id_rs1 = 0; b.id_rs2 = 0;
        #1;
        chk("lu.x0", {31'd0, b.load_use_hazard}, 32'd0);
        check_all("lu_x0");

        // Stall refresh keeps a retired WB value
        clear_inputs();
        b.id_valid = 1; b.id_rs1 = 3; b.id_rs1_data = 0; b.id_alu_src_a = 0; b.id_alu_ctrl = 4'd2;
        clk_edge();
        clear_inputs();
        b.stall = 1; b.wb_rd = 3; b.wb_reg_write = 1; b.wb_result = 32'h40;
        #1;
        chk("stall.c1", b.alu_d0, 32'h40);
        check_all("stall_c1");
        clk_edge();
        b.wb_reg_write = 0; b.wb_result = 0;
        #1;
        chk("stall.c2", b.alu_d0, 32'h40);
        check_all("stall_c2");
        clk_edge();
        check_all("stall_end");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            #1;
            check_all("rnd");
            clk_edge();
        end

        // Asynchronous reset mid-stream with live contents
        clear_inputs();
        b.id_valid = 1; b.id_rd = 6; b.id_mem_read = 1; b.id_reg_write = 1;
        b.id_pc = 32'hABCD0000; b.id_alu_ctrl = 4'd9; b.id_alu_src_a = 1;
        clk_edge();
        b.id_rs1 = 6;
        #1;
        check_all("pre_rst");
        rst_n = 1'b0;
        m = '0;
        #1;
        chk("arst.valid",  {31'd0, b.ex_valid},        32'd0);
        chk("arst.pc",     b.ex_pc,                    32'd0);
        chk("arst.alu_s",  {28'd0, b.alu_s},           32'd0);
        chk("arst.hazard", {31'd0, b.load_use_hazard}, 32'd0);
        check_all("arst");
        #1 rst_n = 1'b1;
        clear_inputs();
        clk_edge();
        check_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and execute-operand front end for the RV32I pipeline. It latches decoded instructions and resolves RAW hazards by forwarding from the MEM and WB stages. It drives the ALU's d0/d1/s inputs directly, supplies forwarded store data and control to EX/MEM, and flags load-use hazards back to the hazard controller.

## Interface
- XLEN, 32, datapath width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold ID/EX contents (refresh operands only)
- flush  in  1  load a bubble on the next edge; priority over stall
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded PC, register-file reads, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_alu_ctrl  in  4  ALU op code (0000 ADD … 1001 SRA)
- id_alu_src_a  in  1  1: d0=PC, 0: d0=rs1
- id_alu_src_b  in  1  1: d1=imm, 0: d1=rs2
- id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded control
- mem_rd  in  5, mem_reg_write  in  1, mem_result  in  XLEN  EX/MEM forwarding source
- wb_rd  in  5, wb_reg_write  in  1, wb_result  in  XLEN  MEM/WB forwarding source
- alu_d0, alu_d1  out  XLEN  ALU operands
- alu_s  out  4  ALU select
- ex_valid  out  1  EX slot valid
- ex_pc  out  XLEN  latched PC
- ex_rd  out  5; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control to EX/MEM
- ex_store_data  out  XLEN  forwarded rs2 value
- load_use_hazard  out  1  combinational hazard flag

## Operation
- Registered fields: valid, pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_ctrl, alu_src_a, alu_src_b, reg_write, mem_read, mem_write.
- Edge priority: flush > stall > normal capture.
- flush: every field is set to its reset value (a bubble).
- stall: all fields hold, except rs1_data <= fwd_rs1 and rs2_data <= fwd_rs2. This keeps operands correct once a forwarding source retires during the stall.
- Normal capture: every field <= id_*. If id_valid=0, the captured reg_write/mem_read/mem_write are forced to 0 and valid=0.
- fwd_rs1 (combinational):
  - mem_result if mem_reg_write && mem_rd!=0 && mem_rd==ex rs1;
  - else wb_result if wb_reg_write && wb_rd!=0 && wb_rd==ex rs1;
  - else latched rs1_data.
- fwd_rs2: same rule against ex rs2. MEM always wins over WB. x0 is never forwarded.
- alu_d0 = alu_src_a ? pc : fwd_rs1.
- alu_d1 = alu_src_b ? imm : fwd_rs2.
- ex_store_data = fwd_rs2, regardless of alu_src_b.
- alu_s = valid ? alu_ctrl : 4'b0000 (ADD for bubbles).
- load_use_hazard = valid && mem_read && rd!=0 && id_valid && (id_rs1==rd || id_rs2==rd).
  - It uses the latched EX fields and does not qualify on rs usage.
  - The controller responds by stalling IF/ID and flushing this block for one cycle. This block takes no action of its own.

## Timing
- Reset (async assert, sync-to-clk deassert handled at top level): all registered fields are 0. Resulting outputs:
  - ex_valid=0, ex_pc=0, ex_rd=0, ex_reg_write=ex_mem_read=ex_mem_write=0;
  - alu_s=0000, alu_d0=0, alu_d1=0, ex_store_data=0;
  - load_use_hazard=0.
- rst_n assertion mid-operation clears state immediately, without waiting for clk.
- Latency: ID inputs appear on ex_*/alu_* one cycle after the capturing edge.
- Forwarding and ALU operand paths are purely combinational from the current-cycle mem_*/wb_* inputs. There is no added cycle.
- flush and stall asserted on the same edge: flush wins and a bubble results.
- A stall may last any number of cycles. Outputs stay stable, except operands that change as mem_*/wb_* forwarding sources change.
- There is no handshake: stall/flush are level-sampled at each rising edge.

## Test plan
- Reset: drive rst_n=0 mid-stream with valid contents latched -> all outputs 0 and alu_s=0000 before the next clk edge.
- Forwarding priority: ex rs1=5; mem_rd=5 with mem_result=0x11111111, wb_rd=5 with wb_result=0x22222222, both write enables 1, alu_src_a=0 -> alu_d0=0x11111111. Deassert mem_reg_write -> alu_d0=0x22222222.
- x0 guard: ex rs2=0, mem_rd=0, mem_reg_write=1, mem_result=0xDEADBEEF, latched rs2_data=0 -> alu_d1=0 and ex_store_data=0.
- Flush vs stall: assert stall=1 and flush=1 together with a valid ADD in EX -> next cycle ex_valid=0, ex_reg_write=0, alu_s=0000.
- Load-use: EX holds lw with rd=7 and mem_read=1; id_valid=1 with id_rs2=7 -> load_use_hazard=1. Same case with rd=0 -> load_use_hazard=0.
- Stall refresh:
  - Stall 2 cycles with ex rs1=3, latched rs1_data=0.
  - Cycle 1: wb_rd=3, wb_reg_write=1, wb_result=0x40 -> alu_d0=0x40.
  - Cycle 2: WB source gone -> alu_d0 still 0x40, taken from the refreshed register.
